// File: rtl/k_fifo_pkg.sv
// Shared FIFO definitions: depth, pointer/count widths and the 2-entry occupancy state encoding.
package k_fifo_pkg;

  localparam int unsigned FIFO2_DEPTH = 2;
  localparam int unsigned FIFO2_PTR_W = 1;
  localparam int unsigned FIFO2_CNT_W = 2;

  // Encoding equals occupancy so the count output is a plain cast of the state.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fifo2_state_e;

endpackage

// File: rtl/k_fifo2_ptr.sv
// 1-bit wrapping RAM pointer: increments on inc, synchronous clear, async active-high reset.
module k_fifo2_ptr
  import k_fifo_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   inc,
  output logic [FIFO2_PTR_W-1:0] ptr
);

  // Pointer register; wrap is the natural overflow of the pointer width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + FIFO2_PTR_W'(1);
    end
  end

endmodule

// File: rtl/k_fifo2_ctrl.sv
// Sequencing controller for the 2-entry dual-port FIFO RAM: turns producer/consumer
// valid/ready handshakes into wen/waddr/raddr and tracks occupancy with a 3-state FSM.
// Optional feature macro: K_FIFO2_CTRL_ERR_EN (sticky handshake protocol checker on err_proto).
module k_fifo2_ctrl
  import k_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   ram_wen,
  output logic [FIFO2_PTR_W-1:0] ram_waddr,
  output logic [FIFO2_PTR_W-1:0] ram_raddr,
  output logic [FIFO2_CNT_W-1:0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   err_proto
);

  // DATA_W only sizes the RAM owned by the parent; a zero width has no meaning.
  if (DATA_W == 0) begin : g_data_w_zero
  end

  fifo2_state_e           state;
  fifo2_state_e           state_nxt;
  logic                   push;
  logic                   pop;
  logic [FIFO2_PTR_W-1:0] wptr;
  logic [FIFO2_PTR_W-1:0] rptr;

  // Status decode from the registered state; ready never looks at out_ready.
  assign count     = FIFO2_CNT_W'(state);
  assign empty     = (count == '0);
  assign full      = (count == FIFO2_CNT_W'(FIFO2_DEPTH));
  assign in_ready  = !full && !flush && !rst;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !flush;
  assign ram_wen   = push;
  assign ram_waddr = wptr;
  assign ram_raddr = rptr;

  // Occupancy state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; flush wins over any handshake in the same cycle.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: if (push) state_nxt = ONE;
        ONE: begin
          if (push && !pop)      state_nxt = FULL;
          else if (pop && !push) state_nxt = EMPTY;
        end
        FULL:  if (pop) state_nxt = ONE;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  k_fifo2_ptr u_wptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (push),
    .ptr (wptr)
  );

  k_fifo2_ptr u_rptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (pop),
    .ptr (rptr)
  );

`ifdef K_FIFO2_CTRL_ERR_EN
  logic in_stall_q;
  logic out_stall_q;
  logic err_q;

  // One-cycle stall history and sticky violation flag; flush clears history too so
  // the flush cycle itself never looks like a withdrawn request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_stall_q  <= 1'b0;
      out_stall_q <= 1'b0;
      err_q       <= 1'b0;
    end else if (flush) begin
      in_stall_q  <= 1'b0;
      out_stall_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      in_stall_q  <= in_valid && !in_ready;
      out_stall_q <= out_valid && !out_ready;
      if ((in_stall_q && !in_valid) || (out_stall_q && !out_valid)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err_proto = err_q;
`else
  assign err_proto = 1'b0;
`endif

endmodule

// File: tb/tb_k_fifo2_ctrl.sv
// Directed self-checking bench for k_fifo2_ctrl with a behavioural 2-entry RAM model.
module tb_k_fifo2_ctrl;

`ifdef K_FIFO2_CTRL_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic       ram_wen;
  logic       ram_waddr;
  logic       ram_raddr;
  logic [1:0] count;
  logic       full;
  logic       empty;
  logic       err_proto;

  logic [7:0] din;
  logic [7:0] mem [2];
  logic [7:0] q;

  int checks;
  int errors;

  k_fifo2_ctrl #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ram_wen   (ram_wen),
    .ram_waddr (ram_waddr),
    .ram_raddr (ram_raddr),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .err_proto (err_proto)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: synchronous write, combinational read.
  always @(posedge clk) if (ram_wen) mem[ram_waddr] <= din;
  assign q = mem[ram_raddr];

  // Pointer invariants, sampled mid-cycle when inputs are stable.
  always @(negedge clk) begin
    #3;
    if (!rst) begin
      checks++;
      if (count == 2'd1) begin
        if (ram_waddr === ram_raddr) begin
          errors++;
          $display("FAIL inv_one: waddr=%0b raddr=%0b must differ", ram_waddr, ram_raddr);
        end
      end else if (count == 2'd0 || count == 2'd2) begin
        if (ram_waddr !== ram_raddr) begin
          errors++;
          $display("FAIL inv_eq: count=%0d waddr=%0b raddr=%0b must match", count, ram_waddr, ram_raddr);
        end
      end else begin
        errors++;
        $display("FAIL inv_count: count=%0d out of range", count);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; din = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL rst_in_ready: got %0b want 0", in_ready); end
    checks++; if (count !== 2'd0)     begin errors++; $display("FAIL rst_count: got %0d want 0", count); end
    checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL rst_empty: got %0b want 1", empty); end
    checks++; if (full !== 1'b0)      begin errors++; $display("FAIL rst_full: got %0b want 0", full); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
    checks++; if (ram_wen !== 1'b0)   begin errors++; $display("FAIL rst_wen: got %0b want 0", ram_wen); end
    checks++; if (err_proto !== 1'b0) begin errors++; $display("FAIL rst_err: got %0b want 0", err_proto); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL rst_release_ready: got %0b want 1", in_ready); end
    checks++; if (ram_wen !== 1'b0)   begin errors++; $display("FAIL idle_wen: got %0b want 0", ram_wen); end
    cycle();
    checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL idle_empty: got %0b want 1", empty); end
  endtask

  task automatic test_fill();
    in_valid = 1'b1; din = 8'hA5; out_ready = 1'b0;
    #1;
    checks++; if (ram_wen !== 1'b1)   begin errors++; $display("FAIL fill_wen0: got %0b want 1", ram_wen); end
    checks++; if (ram_waddr !== 1'b0) begin errors++; $display("FAIL fill_waddr0: got %0b want 0", ram_waddr); end
    cycle();
    din = 8'h3C;
    #1;
    checks++; if (ram_waddr !== 1'b1) begin errors++; $display("FAIL fill_waddr1: got %0b want 1", ram_waddr); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fill_latency: out_valid=%0b want 1", out_valid); end
    checks++; if (q !== 8'hA5)        begin errors++; $display("FAIL fill_q_first: got %h want a5", q); end
    checks++; if (count !== 2'd1)     begin errors++; $display("FAIL fill_count1: got %0d want 1", count); end
    cycle();
    in_valid = 1'b0;
    #1;
    checks++; if (full !== 1'b1)      begin errors++; $display("FAIL fill_full: got %0b want 1", full); end
    checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL fill_ready: got %0b want 0", in_ready); end
    checks++; if (ram_raddr !== 1'b0) begin errors++; $display("FAIL fill_raddr: got %0b want 0", ram_raddr); end
    checks++; if (q !== 8'hA5)        begin errors++; $display("FAIL fill_q_head: got %h want a5", q); end
  endtask

  task automatic test_drain();
    out_ready = 1'b1;
    #1;
    checks++; if (q !== 8'hA5)        begin errors++; $display("FAIL drain_q0: got %h want a5", q); end
    cycle();
    checks++; if (ram_raddr !== 1'b1) begin errors++; $display("FAIL drain_raddr1: got %0b want 1", ram_raddr); end
    checks++; if (q !== 8'h3C)        begin errors++; $display("FAIL drain_q1: got %h want 3c", q); end
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL drain_slot_free: got %0b want 1", in_ready); end
    cycle();
    out_ready = 1'b0;
    #1;
    checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL drain_empty: got %0b want 1", empty); end
    checks++; if (ram_raddr !== 1'b0) begin errors++; $display("FAIL drain_raddr_wrap: got %0b want 0", ram_raddr); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    exp = 8'h01;
    out_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      in_valid = (c < 8);
      din = 8'(c + 1);
      #1;
      if (c == 0) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_first_valid: got %0b want 0", out_valid); end
      end else begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_bubble: cycle %0d out_valid=%0b want 1", c, out_valid); end
        checks++; if (q !== exp)          begin errors++; $display("FAIL b2b_order: cycle %0d got %h want %h", c, q, exp); end
        exp = exp + 8'd1;
      end
      if (c > 0 && c < 8) begin
        checks++; if (count !== 2'd1) begin errors++; $display("FAIL b2b_count: cycle %0d got %0d want 1", c, count); end
      end
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL b2b_empty: got %0b want 1", empty); end
  endtask

  task automatic test_flush();
    in_valid = 1'b1; din = 8'h11; out_ready = 1'b0;
    cycle();
    in_valid = 1'b0; out_ready = 1'b1;
    cycle();
    out_ready = 1'b0; in_valid = 1'b1; din = 8'h22;
    cycle();
    din = 8'h33;
    cycle();
    in_valid = 1'b0;
    #1;
    checks++; if (count !== 2'd2)     begin errors++; $display("FAIL flush_pre_count: got %0d want 2", count); end
    checks++; if (ram_raddr !== 1'b1) begin errors++; $display("FAIL flush_pre_raddr: got %0b want 1", ram_raddr); end
    flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL flush_ready: got %0b want 0", in_ready); end
    checks++; if (ram_wen !== 1'b0)   begin errors++; $display("FAIL flush_wen: got %0b want 0", ram_wen); end
    cycle();
    flush = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (count !== 2'd0)     begin errors++; $display("FAIL flush_count: got %0d want 0", count); end
    checks++; if (ram_waddr !== 1'b0) begin errors++; $display("FAIL flush_wptr: got %0b want 0", ram_waddr); end
    checks++; if (ram_raddr !== 1'b0) begin errors++; $display("FAIL flush_rptr: got %0b want 0", ram_raddr); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %0b want 0", out_valid); end
  endtask

  task automatic test_err_proto();
    in_valid = 1'b1; out_ready = 1'b0; din = 8'h44;
    cycle();
    din = 8'h55;
    cycle();
    // FULL with in_valid still high: one stalled cycle.
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL err_stall_ready: got %0b want 0", in_ready); end
    cycle();
    in_valid = 1'b0;
    #1;
    checks++; if (err_proto !== 1'b0) begin errors++; $display("FAIL err_before: got %0b want 0", err_proto); end
    cycle();
    checks++; if (err_proto !== ERR_EN) begin errors++; $display("FAIL err_set: got %0b want %0b", err_proto, ERR_EN); end
    repeat (2) cycle();
    checks++; if (err_proto !== ERR_EN) begin errors++; $display("FAIL err_sticky: got %0b want %0b", err_proto, ERR_EN); end
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    #1;
    checks++; if (err_proto !== 1'b0) begin errors++; $display("FAIL err_flush_clear: got %0b want 0", err_proto); end
    checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL err_flush_empty: got %0b want 1", empty); end
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1; din = 8'h66; out_ready = 1'b0;
    cycle();
    in_valid = 1'b0;
    #1;
    checks++; if (count !== 2'd1) begin errors++; $display("FAIL arst_pre_count: got %0d want 1", count); end
    #3;
    rst = 1'b1;
    #1;
    checks++; if (count !== 2'd0)     begin errors++; $display("FAIL arst_count: got %0d want 0", count); end
    checks++; if (ram_waddr !== 1'b0) begin errors++; $display("FAIL arst_wptr: got %0b want 0", ram_waddr); end
    checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL arst_ready: got %0b want 0", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL arst_release: got %0b want 1", in_ready); end
    checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL arst_empty: got %0b want 1", empty); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_flush();
    test_err_proto();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/k_fifo2_ctrl.md
# k_fifo2_ctrl

Sequencing controller for the 2-entry dual-port RAM (`k_dp_2deep_ram_t1`) used in the FIFO path. It converts a producer valid/ready stream and a consumer valid/ready stream into the RAM's `wen`/`waddr`/`raddr` controls. It also tracks occupancy with a 3-state FSM and 1-bit pointers. It sits between the upstream stage and the RAM; read data returns from the RAM's combinational `q` straight to the consumer.

## Interface
Parameters:
- DATA_W, 8, datapath width; passed through to the RAM instance.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- flush  in  1  synchronous clear of the FIFO contents.
- in_valid  in  1  producer has a word.
- in_ready  out  1  controller accepts a word this cycle.
- out_valid  out  1  head word is valid on the RAM `q`.
- out_ready  in  1  consumer takes the head word.
- ram_wen  out  1  RAM write enable.
- ram_waddr  out  1  RAM write address (write pointer).
- ram_raddr  out  1  RAM read address (read pointer).
- count  out  2  occupancy, 0..2.
- full  out  1  count == 2.
- empty  out  1  count == 0.
- err_proto  out  1  sticky protocol-violation flag; see Configuration.

## Operation
- Events:
  - push = in_valid && in_ready.
  - pop = out_valid && out_ready.
- FSM states: EMPTY(count 0), ONE(count 1), FULL(count 2).
- Transitions:
  - EMPTY: push → ONE.
  - ONE: push && !pop → FULL; pop && !push → EMPTY; push && pop → ONE.
  - FULL: pop → ONE.
- in_ready = !full && !flush && !rst. There is no pass-through when full, so no combinational path from out_ready to in_ready.
- out_valid = !empty.
- Push and pop in EMPTY: only the push happens, because out_valid is 0.
- ram_wen = push, combinational.
- ram_waddr = wptr; ram_raddr = rptr. Both are registered 1-bit pointers.
- wptr toggles on push; rptr toggles on pop. Wrap from 1 to 0 is natural 1-bit overflow.
- Push and pop in the same cycle: both pointers toggle and the state is unchanged.
- flush: on the next edge, state becomes EMPTY, wptr = rptr = 0, and err_proto clears. Any concurrent pop has no effect. Push cannot happen because in_ready is 0.
- Invariants:
  - wptr == rptr in EMPTY and in FULL.
  - wptr != rptr in ONE.
  - The bench must assert these.

## Timing
- Reset values: state EMPTY, wptr 0, rptr 0, count 0, empty 1, full 0, out_valid 0, in_ready 0 (while rst is high), ram_wen 0, err_proto 0.
- Asserting rst mid-operation discards all contents immediately (asynchronously).
- in_ready rises combinationally once rst deasserts.
- Push-to-out_valid latency: 1 cycle. A word written at edge N drives `q` and out_valid just after edge N.
- Pop frees a slot at the edge: after a pop from FULL, in_ready is 1 in the following cycle.
- Throughput: one push and one pop per cycle in the ONE state indefinitely.

## Configuration
- Macro: K_FIFO2_CTRL_ERR_EN.
- Defined:
  - err_proto sets on an edge where the previous cycle had in_valid && !in_ready and the current cycle has in_valid == 0. This is the producer withdrawing a stalled request.
  - err_proto also sets on an edge where the previous cycle had out_valid && !out_ready and the current cycle's out_valid is 0 without flush or rst. This is an internal consistency check.
  - The flag is sticky until rst or flush.
  - Requires one-cycle history registers.
- Undefined: err_proto is tied to 0 and the history registers are not built.

## Structure
- Shared package `k_fifo_pkg`:
  - FIFO2_DEPTH = 2.
  - FIFO2_PTR_W = 1.
  - FIFO2_CNT_W = 2.
  - State encoding typedef: EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2.
- One sub-module is natural: `k_fifo2_ptr`, a 1-bit toggling pointer with increment enable, synchronous clear and async reset. It is instantiated once for wptr and once for rptr.
- The RAM itself is instantiated by the parent, not inside this controller.

## Test plan
- Reset, then hold in_valid = 0 → empty = 1, count = 0, out_valid = 0, ram_wen = 0, in_ready = 1.
- Push 0xA5, then 0x3C, on consecutive cycles with out_ready = 0:
  - The first push writes waddr 0; the second writes waddr 1.
  - full = 1 and in_ready = 0 on the third cycle.
  - q = 0xA5 at raddr 0.
- From FULL, set out_ready = 1 for 2 cycles:
  - Pops return 0xA5 then 0x3C.
  - rptr goes 0 → 1 → 0.
  - empty = 1 afterwards.
- Stream: in_valid = out_ready = 1 continuously for 8 words 0x01..0x08 → count stays 1 after the first word, output order is 0x01..0x08, and no bubbles.
- Reach FULL, then assert flush together with out_ready = 1 → next cycle: count = 0, wptr = rptr = 0, no pop counted.
- With K_FIFO2_CTRL_ERR_EN defined, in FULL: in_valid = 1 for one stalled cycle, then in_valid = 0 → err_proto = 1 and stays 1 until flush, then reads 0.
